fp_div: RTL and testbench

//  Iterative floating-point divider, the inverse operation of the combinational fp multiplier.

---
 rtl/fp_div_if.sv | 40 ++++
 rtl/fp_div.sv | 175 +++++++++++++++++
 tb/tb_fp_div.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_div_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_div_if
//  Description : Operand/result handshake bundle for the iterative fp divider.
//                Input side:  in_valid/in_ready plus dividend and divisor fields.
//                Output side: out_valid/out_ready plus quotient fields.
//  Revision    : 1.0  initial release
// ============================================================================
interface fp_div_if #(
    parameter int MANT_W = 26,
    parameter int EXP_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              sign_A;
    logic              sign_B;
    logic [EXP_W-1:0]  exp_A;
    logic [EXP_W-1:0]  exp_B;
    logic [MANT_W-1:0] mantis_A;
    logic [MANT_W-1:0] mantis_B;
    logic              out_valid;
    logic              out_ready;
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mantis;
    logic              div_zero;

    // Producer of operands and consumer of results
    modport master (
        output in_valid, sign_A, sign_B, exp_A, exp_B, mantis_A, mantis_B, out_ready,
        input  in_ready, out_valid, sign, exp, mantis, div_zero
    );

    // The divider itself
    modport slave (
        input  in_valid, sign_A, sign_B, exp_A, exp_B, mantis_A, mantis_B, out_ready,
        output in_ready, out_valid, sign, exp, mantis, div_zero
    );
endinterface
`default_nettype wire

// File: rtl/fp_div.sv
`default_nettype none
// ============================================================================
//  Module      : fp_div
//  Description : Iterative floating-point divider, radix-2 restoring, one
//                quotient bit per cycle. Valid/ready handshake on both sides.
//                Optional macro FP_DIV_ROUND_EN adds a guard iteration and
//                round-to-nearest (ties up) on the quotient mantissa.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_div #(
    parameter int MANT_W = 26,
    parameter int EXP_W  = 8,
    parameter int BIAS   = 127
) (
    input  wire logic clk,
    input  wire logic rst_n,
    fp_div_if.slave   bus
);

`ifdef FP_DIV_ROUND_EN
    localparam int c_guard = 1;
`else
    localparam int c_guard = 0;
`endif
    // Quotient bits produced per operation (including the guard bit if any)
    localparam int c_qw    = MANT_W + c_guard;
    // Remainder and divisor are kept scaled by two so the pre-align shift of
    // the dividend never drops its LSB.
    localparam int c_rem_w = MANT_W + 2;
    localparam int c_cnt_w = $clog2(c_qw + 1);

    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(c_qw);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [EXP_W-1:0]   c_bias    = EXP_W'(BIAS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic                sign_q,   sign_d;
    logic [EXP_W-1:0]    exp_q,    exp_d;
    logic [MANT_W-1:0]   mant_q,   mant_d;
    logic                dz_q,     dz_d;
    logic                azero_q,  azero_d;
    logic [c_rem_w-1:0]  rem_q,    rem_d;
    logic [c_rem_w-1:0]  dvs_q,    dvs_d;
    logic [c_qw-1:0]     quo_q,    quo_d;
    logic [c_cnt_w-1:0]  cnt_q,    cnt_d;

    logic                w_adj;
    logic [c_rem_w-1:0]  w_shift;

    // Dividend at least as large as divisor: quotient would be >= 1, so halve it
    assign w_adj   = (bus.mantis_A >= bus.mantis_B);
    // Remainder stays below the divisor, so the shifted-out MSB is always zero
    assign w_shift = rem_q << 1;

`ifdef FP_DIV_ROUND_EN
    logic [MANT_W:0] w_rnd;
    // Truncated quotient plus the guard bit; MSB is the carry-out
    assign w_rnd = {1'b0, quo_q[c_qw-1:1]} + {{MANT_W{1'b0}}, quo_q[0]};
`endif

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.sign      = sign_q;
    assign bus.exp       = exp_q;
    assign bus.mantis    = mant_q;
    assign bus.div_zero  = dz_q;

    // Next-state and datapath update for the accept / iterate / hold sequence
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        dz_d    = dz_q;
        azero_d = azero_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.sign_A ^ bus.sign_B;
                    exp_d   = bus.exp_A - bus.exp_B + c_bias + {{(EXP_W-1){1'b0}}, w_adj};
                    rem_d   = w_adj ? {2'b00, bus.mantis_A} : {1'b0, bus.mantis_A, 1'b0};
                    dvs_d   = {1'b0, bus.mantis_B, 1'b0};
                    quo_d   = '0;
                    cnt_d   = '0;
                    dz_d    = (bus.mantis_B == '0);
                    azero_d = (bus.mantis_A == '0);
                    state_d = S_DIV;
                end
            end

            S_DIV: begin
                if (dz_q) begin
                    // Division by zero: saturated result, no iterations
                    exp_d   = '1;
                    mant_d  = '1;
                    state_d = S_DONE;
                end else if (cnt_q == c_last) begin
`ifdef FP_DIV_ROUND_EN
                    if (w_rnd[MANT_W]) begin
                        mant_d = {1'b1, {(MANT_W-1){1'b0}}};
                        exp_d  = exp_q + {{(EXP_W-1){1'b0}}, 1'b1};
                    end else begin
                        mant_d = w_rnd[MANT_W-1:0];
                    end
`else
                    mant_d = quo_q;
`endif
                    // Zero dividend gives a true zero, not a biased exponent
                    if (azero_q) begin
                        mant_d = '0;
                        exp_d  = '0;
                    end
                    state_d = S_DONE;
                end else begin
                    if (w_shift >= dvs_q) begin
                        rem_d = w_shift - dvs_q;
                        quo_d = {quo_q[c_qw-2:0], 1'b1};
                    end else begin
                        rem_d = w_shift;
                        quo_d = {quo_q[c_qw-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            dz_q    <= 1'b0;
            azero_q <= 1'b0;
            rem_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            dz_q    <= dz_d;
            azero_q <= azero_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_div
//  Description : Self-checking bench for fp_div: reset, directed vectors,
//                random operands against an arithmetic reference model,
//                back-pressure, back-to-back handshake and mid-op reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_div;
    localparam int MW = 26;
    localparam int EW = 8;
`ifdef FP_DIV_ROUND_EN
    localparam int LAT = MW + 2;
    localparam logic [MW-1:0] TWO_THIRDS = 26'h2AAAAAB;
`else
    localparam int LAT = MW + 1;
    localparam logic [MW-1:0] TWO_THIRDS = 26'h2AAAAAA;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fp_div_if #(.MANT_W(MW), .EXP_W(EW)) bus();

    fp_div #(.MANT_W(MW), .EXP_W(EW), .BIAS(127)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: quotient = A/B as a real ratio, scaled into [0.5,1) by adj
    function automatic void ref_div(input logic sa, input logic [EW-1:0] ea, input logic [MW-1:0] ma,
                                    input logic sb, input logic [EW-1:0] eb, input logic [MW-1:0] mb,
                                    output logic [35:0] r, output int rlat);
        longint a, b, q, m;
        int     e;
        bit     adj;
        a = longint'(ma);
        b = longint'(mb);
        if (b == 0) begin
            r    = {sa ^ sb, 8'hFF, 26'h3FFFFFF, 1'b1};
            rlat = 1;
            return;
        end
        adj = (a >= b);
`ifdef FP_DIV_ROUND_EN
        q = adj ? (a << 26) / b : (a << 27) / b;
        m = (q >> 1) + (q & 1);
`else
        q = adj ? (a << 25) / b : (a << 26) / b;
        m = q;
`endif
        rlat = LAT;
        e = int'(ea) - int'(eb) + 127 + (adj ? 1 : 0);
        if (m == (longint'(1) << 26)) begin
            m = longint'(1) << 25;
            e = e + 1;
        end
        if (a == 0) begin
            m = 0;
            e = 0;
        end
        r = {sa ^ sb, 8'(e), 26'(m), 1'b0};
    endfunction

    function automatic logic [MW-1:0] rand_mant(input int zero_one_in);
        if ($urandom_range(0, zero_one_in - 1) == 0) return '0;
        return {1'b1, 25'($urandom)};
    endfunction

    task automatic drive_ops(input logic sa, input logic [EW-1:0] ea, input logic [MW-1:0] ma,
                             input logic sb, input logic [EW-1:0] eb, input logic [MW-1:0] mb);
        bus.sign_A = sa; bus.exp_A = ea; bus.mantis_A = ma;
        bus.sign_B = sb; bus.exp_B = eb; bus.mantis_B = mb;
    endtask

    task automatic start_op(input logic sa, input logic [EW-1:0] ea, input logic [MW-1:0] ma,
                            input logic sb, input logic [EW-1:0] eb, input logic [MW-1:0] mb);
        @(negedge clk);
        drive_ops(sa, ea, ma, sb, eb, mb);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Count rising edges until out_valid; 0 means it never arrived
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic release_result(input int hold);
        repeat (hold) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input logic sa, input logic [EW-1:0] ea, input logic [MW-1:0] ma,
                          input logic sb, input logic [EW-1:0] eb, input logic [MW-1:0] mb,
                          input int hold, output logic [35:0] got, output int lat);
        start_op(sa, ea, ma, sb, eb, mb);
        wait_valid(lat);
        got = {bus.sign, bus.exp, bus.mantis, bus.div_zero};
        release_result(hold);
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.sign !== 1'b0) begin bad++; $display("FAIL reset_sign got=%b exp=0", bus.sign); end
        total++; if (bus.exp !== 8'h00) begin bad++; $display("FAIL reset_exp got=%h exp=00", bus.exp); end
        total++; if (bus.mantis !== 26'h0) begin bad++; $display("FAIL reset_mantis got=%h exp=0", bus.mantis); end
        total++; if (bus.div_zero !== 1'b0) begin bad++; $display("FAIL reset_div_zero got=%b exp=0", bus.div_zero); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic          sa_t[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [EW-1:0] ea_t[7] = '{8'd130, 8'd127, 8'd127, 8'd100, 8'd140, 8'd10, 8'd255};
        logic [MW-1:0] ma_t[7] = '{26'h3000000, 26'h2000000, 26'h2000000, 26'h0, 26'h3000000, 26'h3000000, 26'h2000000};
        logic          sb_t[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [EW-1:0] eb_t[7] = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd200, 8'd1};
        logic [MW-1:0] mb_t[7] = '{26'h2000000, 26'h2000000, 26'h3000000, 26'h2000000, 26'h0, 26'h2000000, 26'h3000000};
        logic [35:0]   ex_t[7];
        int            lt_t[7] = '{LAT, LAT, LAT, LAT, 1, LAT, LAT};
        logic [35:0]   got;
        int            lat;
        ex_t[0] = {1'b0, 8'd131, 26'h3000000, 1'b0};
        ex_t[1] = {1'b1, 8'd128, 26'h2000000, 1'b0};
        ex_t[2] = {1'b0, 8'd127, TWO_THIRDS, 1'b0};
        ex_t[3] = {1'b1, 8'd0, 26'h0, 1'b0};
        ex_t[4] = {1'b1, 8'hFF, 26'h3FFFFFF, 1'b1};
        ex_t[5] = {1'b0, 8'hC2, 26'h3000000, 1'b0};
        ex_t[6] = {1'b0, 8'd125, TWO_THIRDS, 1'b0};
        for (int i = 0; i < 7; i++) begin
            run_op(sa_t[i], ea_t[i], ma_t[i], sb_t[i], eb_t[i], mb_t[i], 0, got, lat);
            total++;
            if (got !== ex_t[i]) begin
                bad++; $display("FAIL directed_%0d result got=%h exp=%h", i, got, ex_t[i]);
            end
            total++;
            if (lat !== lt_t[i]) begin
                bad++; $display("FAIL directed_%0d latency got=%0d exp=%0d", i, lat, lt_t[i]);
            end
        end
    endtask

    task automatic test_random();
        logic          sa, sb;
        logic [EW-1:0] ea, eb;
        logic [MW-1:0] ma, mb;
        logic [35:0]   got, exp_r;
        int            lat, exp_lat;
        for (int i = 0; i < 40; i++) begin
            sa = 1'($urandom); sb = 1'($urandom);
            ea = EW'($urandom); eb = EW'($urandom);
            ma = rand_mant(10); mb = rand_mant(10);
            run_op(sa, ea, ma, sb, eb, mb, $urandom_range(0, 3), got, lat);
            ref_div(sa, ea, ma, sb, eb, mb, exp_r, exp_lat);
            total++;
            if (got !== exp_r) begin
                bad++; $display("FAIL random_%0d A=%h/%h B=%h/%h got=%h exp=%h", i, ea, ma, eb, mb, got, exp_r);
            end
            total++;
            if (lat !== exp_lat) begin
                bad++; $display("FAIL random_%0d latency got=%0d exp=%0d", i, lat, exp_lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [MW-1:0] ma, mb;
        logic [35:0]   cap, exp_r;
        int            lat, exp_lat;
        ma = rand_mant(1000); mb = rand_mant(1000);
        start_op(1'b1, 8'd140, ma, 1'b1, 8'd120, mb);
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin lat = k; break; end
            if (k == 4 || k == 11) begin
                drive_ops(1'b0, 8'd1, 26'h2000001, 1'b0, 8'd2, 26'h3FFFFFF);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        ref_div(1'b1, 8'd140, ma, 1'b1, 8'd120, mb, exp_r, exp_lat);
        cap = {bus.sign, bus.exp, bus.mantis, bus.div_zero};
        total++;
        if (cap !== exp_r || lat !== exp_lat) begin
            bad++; $display("FAIL backpressure result got=%h/%0d exp=%h/%0d", cap, lat, exp_r, exp_lat);
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            total++;
            if ({bus.out_valid, bus.in_ready, bus.sign, bus.exp, bus.mantis, bus.div_zero} !== {2'b10, exp_r}) begin
                bad++;
                $display("FAIL backpressure_hold_%0d got v=%b r=%b %h exp v=1 r=0 %h", k, bus.out_valid,
                         bus.in_ready, {bus.sign, bus.exp, bus.mantis, bus.div_zero}, exp_r);
            end
        end
        release_result(0);
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL backpressure_after got v=%b r=%b exp v=0 r=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [MW-1:0] ma1, mb1, ma2, mb2;
        logic [35:0]   got, exp_r;
        int            lat, exp_lat;
        ma1 = rand_mant(1000); mb1 = rand_mant(1000);
        ma2 = rand_mant(1000); mb2 = rand_mant(1000);
        start_op(1'b0, 8'd90, ma1, 1'b1, 8'd80, mb1);
        wait_valid(lat);
        ref_div(1'b0, 8'd90, ma1, 1'b1, 8'd80, mb1, exp_r, exp_lat);
        got = {bus.sign, bus.exp, bus.mantis, bus.div_zero};
        total++;
        if (got !== exp_r || lat !== exp_lat) begin
            bad++; $display("FAIL b2b_first got=%h/%0d exp=%h/%0d", got, lat, exp_r, exp_lat);
        end
        bus.out_ready = 1'b1;
        drive_ops(1'b1, 8'd60, ma2, 1'b0, 8'd70, mb2);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_handshake_edge got r=%b v=%b exp r=1 v=0", bus.in_ready, bus.out_valid);
        end
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_accept got in_ready=%b exp=0", bus.in_ready);
        end
        wait_valid(lat);
        ref_div(1'b1, 8'd60, ma2, 1'b0, 8'd70, mb2, exp_r, exp_lat);
        got = {bus.sign, bus.exp, bus.mantis, bus.div_zero};
        total++;
        if (got !== exp_r || lat !== exp_lat) begin
            bad++; $display("FAIL b2b_second got=%h/%0d exp=%h/%0d", got, lat, exp_r, exp_lat);
        end
        release_result(1);
    endtask

    task automatic test_reset_mid();
        logic [MW-1:0] ma, mb;
        logic [35:0]   got, exp_r;
        int            lat, exp_lat;
        start_op(1'b1, 8'd130, 26'h3000000, 1'b0, 8'd127, 26'h2000000);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.mantis !== 26'h0 || bus.exp !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid got v=%b r=%b e=%h m=%h exp v=0 r=1 e=00 m=0", bus.out_valid,
                     bus.in_ready, bus.exp, bus.mantis);
        end
        @(negedge clk) rst_n = 1'b1;
        ma = rand_mant(1000); mb = rand_mant(1000);
        run_op(1'b0, 8'd33, ma, 1'b1, 8'd44, mb, 0, got, lat);
        ref_div(1'b0, 8'd33, ma, 1'b1, 8'd44, mb, exp_r, exp_lat);
        total++;
        if (got !== exp_r || lat !== exp_lat) begin
            bad++; $display("FAIL reset_mid_next got=%h/%0d exp=%h/%0d", got, lat, exp_r, exp_lat);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_ops(1'b0, '0, '0, 1'b0, '0, '0);
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
